// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronises uart_rxd, detects the start bit, then samples each bit at its centre.
// Emits a one-cycle uart_en with the byte, or a one-cycle frame_err when the stop bit is low.
module uart_byte_rx #(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_rxd,
   output logic       uart_en,
   output logic [7:0] uart_data,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BPS_CNT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic             rxd_s1, rxd_s2, rxd_d;
   logic             fall;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       data_reg, data_next;
   logic             en_reg, en_next;
   logic             err_reg, err_next;
   logic             sample_data;

   assign fall = rxd_d & ~rxd_s2;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         rxd_s1       <= 1'b1;
         rxd_s2       <= 1'b1;
         rxd_d        <= 1'b1;
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         data_reg     <= '0;
         en_reg       <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         rxd_s1       <= uart_rxd;
         rxd_s2       <= rxd_s1;
         rxd_d        <= rxd_s2;
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         data_reg     <= data_next;
         en_reg       <= en_next;
         err_reg      <= err_next;
      end
   end

   // Only the shift bit addressed by bit_cnt captures the line at a data-bit centre.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_shift
         assign shift_next[gi] = (sample_data && (bit_cnt_reg == 3'(gi))) ? rxd_s2 : shift_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      data_next     = data_reg;
      en_next       = 1'b0;
      err_next      = 1'b0;
      sample_data   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next    = START;
               baud_cnt_next = '0;
            end
         end
         START: begin
            // A line that is high again at mid start bit was only a glitch.
            if (baud_cnt_reg == HALF_LAST) begin
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               state_next    = rxd_s2 ? IDLE : DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end
         DATA: begin
            if (baud_cnt_reg == BAUD_LAST) begin
               baud_cnt_next = '0;
               sample_data   = 1'b1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end
         STOP: begin
            // Leaving at mid stop bit lets an immediately following start bit be caught.
            if (baud_cnt_reg == BAUD_LAST) begin
               baud_cnt_next = '0;
               state_next    = IDLE;
               if (rxd_s2) begin
                  data_next = shift_reg;
                  en_next   = 1'b1;
               end else begin
                  err_next  = 1'b1;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign uart_en   = en_reg;
   assign uart_data = data_reg;
   assign frame_err = err_reg;
   assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 10 clocks per bit: table of single frames plus
// hand-written glitch, back-to-back, mid-frame reset and line-break sequences.
module tb_uart_byte_rx;

   localparam int BPS = 10;
   localparam int LAT = 98;   // frame start drive cycle -> strobe cycle (2 sync + 96)

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       uart_rxd;
   logic       uart_en;
   logic [7:0] uart_data;
   logic       frame_err;
   logic       rx_busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int         en_cyc_q[$];
   logic [7:0] en_dat_q[$];
   int         err_cyc_q[$];
   int         both_cnt = 0;

   uart_byte_rx #(
      .CLK_FREQ(1000000),
      .UART_BPS(100000)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .uart_rxd (uart_rxd),
      .uart_en  (uart_en),
      .uart_data(uart_data),
      .frame_err(frame_err),
      .rx_busy  (rx_busy)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (uart_en) begin
         en_cyc_q.push_back(cyc);
         en_dat_q.push_back(uart_data);
      end
      if (frame_err) err_cyc_q.push_back(cyc);
      if (uart_en && frame_err) both_cnt++;
   end

   typedef struct {
      logic [7:0] byte_val;
      logic       stop_bit;
      int         exp_en;
      int         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clear_log();
      en_cyc_q.delete();
      en_dat_q.delete();
      err_cyc_q.delete();
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge sys_clk);
   endtask

   // Called on a negedge; returns the cycle in which the start bit was first driven.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
      logic [9:0] bits;
      bits      = {stop, b, 1'b0};
      start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         uart_rxd = bits[i];
         repeat (BPS) @(negedge sys_clk);
      end
   endtask

   initial begin
      int n, n2;

      vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
      vecs[1] = '{8'hA5, 1'b0, 0, 1, 8'h55};
      vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[4] = '{8'hC3, 1'b0, 0, 1, 8'hFF};
      vecs[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C};

      sys_rst  = 1'b0;
      uart_rxd = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk("reset_en",   uart_en,   0);
      chk("reset_err",  frame_err, 0);
      chk("reset_data", uart_data, 0);
      chk("reset_busy", rx_busy,   0);
      $display("reset: en=%0d err=%0d data=%02h busy=%0d", uart_en, frame_err, uart_data, rx_busy);
      sys_rst = 1'b1;
      idle(5);

      foreach (vecs[i]) begin
         clear_log();
         send_frame(vecs[i].byte_val, vecs[i].stop_bit, n);
         idle(20);
         chk("vec_en_count",  en_cyc_q.size(),  vecs[i].exp_en);
         chk("vec_err_count", err_cyc_q.size(), vecs[i].exp_err);
         chk("vec_data",      uart_data,        vecs[i].exp_data);
         if (vecs[i].exp_en == 1 && en_cyc_q.size() > 0)
            chk("vec_en_latency", en_cyc_q[0] - n, LAT);
         if (vecs[i].exp_err == 1 && err_cyc_q.size() > 0)
            chk("vec_err_latency", err_cyc_q[0] - n, LAT);
         $display("frame %02h stop=%0d: en=%0d err=%0d data=%02h", vecs[i].byte_val,
                  vecs[i].stop_bit, en_cyc_q.size(), err_cyc_q.size(), uart_data);
      end

      // Three-clock low pulse: start bit rejected at its centre
      clear_log();
      n = cyc;
      uart_rxd = 1'b0;
      repeat (3) @(negedge sys_clk);
      uart_rxd = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk("glitch_busy_mid", rx_busy, 1);
      repeat (3) @(negedge sys_clk);
      chk("glitch_busy_after", rx_busy, 0);
      idle(110);
      chk("glitch_en_count",  en_cyc_q.size(),  0);
      chk("glitch_err_count", err_cyc_q.size(), 0);
      $display("glitch at cycle %0d: en=%0d err=%0d", n, en_cyc_q.size(), err_cyc_q.size());

      // Back-to-back frames with no idle gap
      clear_log();
      send_frame(8'hA5, 1'b1, n);
      send_frame(8'h3C, 1'b1, n2);
      idle(20);
      chk("b2b_en_count", en_cyc_q.size(), 2);
      if (en_cyc_q.size() == 2) begin
         chk("b2b_first_latency", en_cyc_q[0] - n, LAT);
         chk("b2b_spacing",       en_cyc_q[1] - en_cyc_q[0], 100);
         chk("b2b_data0",         en_dat_q[0], 8'hA5);
         chk("b2b_data1",         en_dat_q[1], 8'h3C);
      end
      chk("b2b_err_count", err_cyc_q.size(), 0);
      $display("back-to-back: en=%0d last data=%02h", en_cyc_q.size(), uart_data);

      // Reset pulse in the middle of data bit 4 of an 8'hFF frame
      clear_log();
      n = cyc;
      uart_rxd = 1'b0;
      repeat (BPS) @(negedge sys_clk);
      uart_rxd = 1'b1;
      repeat (45) @(negedge sys_clk);
      chk("rst_busy_before", rx_busy, 1);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      sys_rst = 1'b1;
      chk("rst_data_cleared", uart_data, 0);
      chk("rst_busy_cleared", rx_busy,   0);
      idle(100);
      chk("rst_en_count",  en_cyc_q.size(),  0);
      chk("rst_err_count", err_cyc_q.size(), 0);
      send_frame(8'h81, 1'b1, n);
      idle(20);
      chk("rst_next_en_count", en_cyc_q.size(), 1);
      chk("rst_next_data",     uart_data,       8'h81);
      $display("mid-frame reset then frame 81: en=%0d data=%02h", en_cyc_q.size(), uart_data);

      // Line break: 300 low clocks, idle, then a good frame
      clear_log();
      n = cyc;
      uart_rxd = 1'b0;
      repeat (300) @(negedge sys_clk);
      idle(50);
      send_frame(8'h0F, 1'b1, n2);
      idle(20);
      chk("break_err_count", err_cyc_q.size(), 1);
      if (err_cyc_q.size() > 0) chk("break_err_latency", err_cyc_q[0] - n, LAT);
      chk("break_en_count", en_cyc_q.size(), 1);
      if (en_cyc_q.size() > 0) begin
         chk("break_en_latency", en_cyc_q[0] - n2, LAT);
         chk("break_en_data",    en_dat_q[0], 8'h0F);
      end
      $display("break then frame 0f: err=%0d en=%0d data=%02h", err_cyc_q.size(),
               en_cyc_q.size(), uart_data);

      chk("en_err_exclusive", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
